// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing with a req/ready memory port.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
   parameter int WIDTH    = 32,
   parameter int FN_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_b5,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_en,
   output logic                pc_en,
   output logic [1:0]          pc_src,
   output logic                alu_src_b,
   output logic [FN_WIDTH-1:0] alu_fn,
   output logic                rf_wr_en,
   output logic [1:0]          wb_sel,
   output logic                halted,
   output logic [2:0]          state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [WIDTH-1:0]    cycle_cnt,
   output logic [WIDTH-1:0]    instret_cnt
`endif
);

   // Handshake: mem_req (with mem_we/mem_addr_sel) is held from assertion through the
   // cycle in which mem_ready is sampled high; that cycle completes the access.

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
   } state_t;

   state_t state_q, state_d;
   logic   started_q;

   logic is_r, is_i, is_lw, is_sw, is_br, is_jal, legal;

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_lw  = (opcode == OP_LW) && (funct3 == 3'b010);
   assign is_sw  = (opcode == OP_SW) && (funct3 == 3'b010);
   assign is_br  = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
   assign is_jal = (opcode == OP_JAL);
   assign legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal;

   // started_q keeps the first request one cycle clear of reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_en        = 1'b0;
      pc_en        = 1'b0;
      pc_src       = 2'd0;
      alu_src_b    = 1'b0;
      alu_fn       = '0;
      rf_wr_en     = 1'b0;
      wb_sel       = 2'd0;
      halted       = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (started_q) begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_en   = 1'b1;
                  pc_en   = 1'b1;
                  state_d = S_DECODE;
               end
            end
         end
         S_DECODE: state_d = legal ? S_EXECUTE : S_HALT;
         S_EXECUTE: begin
            if (is_r) begin
               alu_fn  = FN_WIDTH'({funct7_b5, funct3});
               state_d = S_WB;
            end else if (is_i) begin
               alu_src_b = 1'b1;
               alu_fn    = FN_WIDTH'({(funct3 == 3'b101) & funct7_b5, funct3});
               state_d   = S_WB;
            end else if (is_lw || is_sw) begin
               alu_src_b = 1'b1;
               state_d   = S_MEM;
            end else if (is_br) begin
               // Branch compares via SUB; funct3[0] selects BNE.
               alu_fn  = FN_WIDTH'(4'b1000);
               pc_src  = 2'd1;
               pc_en   = funct3[0] ? !alu_zero : alu_zero;
               state_d = S_FETCH;
            end else if (is_jal) begin
               pc_src  = 2'd1;
               pc_en   = 1'b1;
               state_d = S_WB;
            end else begin
               state_d = S_HALT;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_sw;
            if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
         end
         S_WB: begin
            rf_wr_en = 1'b1;
            wb_sel   = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
            state_d  = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_HALT;
      endcase
   end

   assign state_dbg = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [WIDTH-1:0] cycle_cnt_q, instret_cnt_q;

   // An instruction retires on the cycle that hands control back to FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (!halted) cycle_cnt_q <= cycle_cnt_q + 1'b1;
         if (state_d == S_FETCH && state_q != S_FETCH) instret_cnt_q <= instret_cnt_q + 1'b1;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule
